cargador_bloque: RTL and testbench

- Upstream feeder and controller for the hashing core.
- Accepts a byte-serial stream: 12 block bytes followed by 1 target byte, over a valid/ready handshake.
- Presents `bloque_bytes` and `target` in parallel, holds the core in reset while loading, then releases it and drives `inicio`.
- Waits for `terminado`, captures the 24-bit hash, reports it with a one-cycle valid pulse and returns to idle for the next block.

---
 rtl/cargador_pkg.sv | 16 +
 rtl/cargador_bloque_if.sv | 12 +
 rtl/cargador_shift.sv | 67 ++++++
 rtl/cargador_bloque.sv | 127 ++++++++++++
 tb/tb_cargador_bloque.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cargador_pkg.sv
// Shared types and constants for the block loader that feeds the hashing core.
package cargador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } estado_t;

  localparam int          N_BYTES_DEF    = 12;
  localparam logic [15:0] MAX_CICLOS_DEF = 16'hFFFF;
  localparam int          HASH_W         = 24;
  localparam int          BYTE_W         = 8;

endpackage

// File: rtl/cargador_bloque_if.sv
// Byte-serial valid/ready stream into the block loader.
interface cargador_bloque_if;
  import cargador_pkg::*;

  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);

endinterface

// File: rtl/cargador_shift.sv
// Byte-slot write register: places each accepted byte into its slot, the last one into target.
module cargador_shift
  import cargador_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  clr,
  input  logic [BYTE_W-1:0]     byte_in,
  output logic [8*N_BYTES-1:0]  bloque_bytes,
  output logic [BYTE_W-1:0]     target,
  output logic                  last
);

  localparam int CNT_W = $clog2(N_BYTES + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] target_q, target_d;

  assign last   = (cnt_q == CNT_W'(N_BYTES));
  assign target = target_q;

  always_comb begin
    cnt_d    = cnt_q;
    target_d = target_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_en) begin
      if (last) begin
        target_d = byte_in;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // Slot 0 is the first stream byte and sits in the most significant byte.
  for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_slot
    logic [BYTE_W-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (wr_en && !clr && !last && (cnt_q == CNT_W'(gi))) slot_d = byte_in;
    end

    always_ff @(posedge clk) begin
      if (reset) slot_q <= '0;
      else       slot_q <= slot_d;
    end

    assign bloque_bytes[(N_BYTES-1-gi)*BYTE_W +: BYTE_W] = slot_q;
  end

endmodule

// File: rtl/cargador_bloque.sv
// Loads a block plus target into the hashing core, runs it and captures the hash.
// Optional RUN watchdog enabled by defining CARGA_TIMEOUT_EN.
module cargador_bloque
  import cargador_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEF
`ifdef CARGA_TIMEOUT_EN
  , parameter logic [15:0] MAX_CICLOS = MAX_CICLOS_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  cargador_bloque_if.slave      bus,
  input  logic                  abortar,
  input  logic                  terminado,
  input  logic [HASH_W-1:0]     hash_in,
  output logic [8*N_BYTES-1:0]  bloque_bytes,
  output logic [BYTE_W-1:0]     target,
  output logic                  inicio,
  output logic                  core_reset_n,
  output logic [HASH_W-1:0]     hash_out,
  output logic                  hash_valid,
  output logic                  busy
`ifdef CARGA_TIMEOUT_EN
  , output logic                timeout
`endif
);

  estado_t           state_q, state_d;
  logic              xfer, last, capture;
  logic              inicio_q, inicio_d;
  logic              core_reset_n_q, core_reset_n_d;
  logic [HASH_W-1:0] hash_out_q, hash_out_d;
  logic              hash_valid_q, hash_valid_d;

`ifdef CARGA_TIMEOUT_EN
  logic [15:0] run_cnt_q, run_cnt_d;
  logic        timeout_q, timeout_d;
  logic        run_lim;

  assign run_lim = ((run_cnt_q + 16'd1) == MAX_CICLOS);
  assign timeout = timeout_q;
`endif

  assign bus.byte_ready = ((state_q == IDLE) || (state_q == LOAD)) && !abortar && !reset;
  assign xfer           = bus.byte_valid && bus.byte_ready;

  cargador_shift #(.N_BYTES(N_BYTES)) u_shift (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (xfer),
    .clr          (abortar),
    .byte_in      (bus.byte_in),
    .bloque_bytes (bloque_bytes),
    .target       (target),
    .last         (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abortar) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (xfer) state_d = LOAD;
        LOAD: if (xfer && last) state_d = RUN;
        RUN: begin
          if (terminado) state_d = DONE;
`ifdef CARGA_TIMEOUT_EN
          else if (run_lim) state_d = DONE;
`endif
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Core controls are registered from the next state so they rise with the first RUN cycle.
  always_comb begin
    capture        = (state_q == RUN) && !abortar && terminado;
    inicio_d       = (state_d == RUN);
    core_reset_n_d = (state_d == RUN);
    hash_valid_d   = capture;
    hash_out_d     = capture ? hash_in : hash_out_q;
`ifdef CARGA_TIMEOUT_EN
    run_cnt_d = ((state_q == RUN) && (state_d == RUN)) ? run_cnt_q + 16'd1 : 16'd0;
    timeout_d = timeout_q;
    if (xfer) timeout_d = 1'b0;
    if ((state_q == RUN) && !abortar && !terminado && run_lim) timeout_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inicio_q       <= 1'b0;
      core_reset_n_q <= 1'b0;
      hash_out_q     <= '0;
      hash_valid_q   <= 1'b0;
`ifdef CARGA_TIMEOUT_EN
      run_cnt_q      <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      inicio_q       <= inicio_d;
      core_reset_n_q <= core_reset_n_d;
      hash_out_q     <= hash_out_d;
      hash_valid_q   <= hash_valid_d;
`ifdef CARGA_TIMEOUT_EN
      run_cnt_q      <= run_cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign inicio       = inicio_q;
  assign core_reset_n = core_reset_n_q;
  assign hash_out     = hash_out_q;
  assign hash_valid   = hash_valid_q;
  assign busy         = (state_q == LOAD) || (state_q == RUN);

endmodule

// File: tb/tb_cargador_bloque.sv
// Bench for cargador_bloque: transaction-level model plus directed and random stimulus.
module tb_cargador_bloque;

  logic        clk = 1'b0;
  logic        reset, abortar, terminado;
  logic [23:0] hash_in;
  logic [95:0] bloque_bytes;
  logic [7:0]  target;
  logic        inicio, core_reset_n, hash_valid, busy;
  logic [23:0] hash_out;
`ifdef CARGA_TIMEOUT_EN
  logic        timeout;
  localparam int MAXC = 16;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  cargador_bloque_if bus ();

  always #5 clk = ~clk;

  cargador_bloque #(
    .N_BYTES(12)
`ifdef CARGA_TIMEOUT_EN
    , .MAX_CICLOS(16'd16)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .abortar      (abortar),
    .terminado    (terminado),
    .hash_in      (hash_in),
    .bloque_bytes (bloque_bytes),
    .target       (target),
    .inicio       (inicio),
    .core_reset_n (core_reset_n),
    .hash_out     (hash_out),
    .hash_valid   (hash_valid),
    .busy         (busy)
`ifdef CARGA_TIMEOUT_EN
    , .timeout    (timeout)
`endif
  );

  // Model: bytes received so far, whether the core is running, and the one-cycle done slot.
  logic [7:0]  m_bytes [13];
  int          m_n;
  bit          m_run, m_done, m_hv;
  logic [23:0] m_hash;
`ifdef CARGA_TIMEOUT_EN
  int          m_rc;
  bit          m_to;
`endif

  function automatic logic [95:0] exp_block();
    logic [95:0] v = '0;
    for (int i = 0; i < 12; i++) v[(11-i)*8 +: 8] = m_bytes[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    bit rdy, acc;
    for (int i = 0; i < 13; i++) m_bytes[i] = 8'h00;
    m_n = 0; m_run = 0; m_done = 0; m_hv = 0; m_hash = '0;
`ifdef CARGA_TIMEOUT_EN
    m_rc = 0; m_to = 0;
`endif
    forever begin
      @(posedge clk);
      rdy  = !reset && !abortar && !m_run && !m_done;
      acc  = rdy && bus.byte_valid;
      m_hv = 0;
      if (reset) begin
        for (int i = 0; i < 13; i++) m_bytes[i] = 8'h00;
        m_n = 0; m_run = 0; m_done = 0; m_hash = '0;
`ifdef CARGA_TIMEOUT_EN
        m_rc = 0; m_to = 0;
`endif
      end else if (abortar) begin
        m_n = 0; m_run = 0; m_done = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (terminado) begin
          m_hash = hash_in; m_hv = 1; m_run = 0; m_done = 1;
        end
`ifdef CARGA_TIMEOUT_EN
        else begin
          m_rc++;
          if (m_rc == MAXC) begin m_run = 0; m_done = 1; m_to = 1; end
        end
`endif
      end else if (acc) begin
        m_bytes[m_n] = bus.byte_in;
`ifdef CARGA_TIMEOUT_EN
        m_to = 0;
`endif
        if (m_n == 12) begin
          m_n = 0; m_run = 1;
`ifdef CARGA_TIMEOUT_EN
          m_rc = 0;
`endif
        end else begin
          m_n++;
        end
      end
      cyc++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("byte_ready", 96'(bus.byte_ready), 96'(!reset && !abortar && !m_run && !m_done));
        check("busy", 96'(busy), 96'((m_n > 0) || m_run));
        check("inicio", 96'(inicio), 96'(m_run));
        check("core_reset_n", 96'(core_reset_n), 96'(m_run));
        check("hash_valid", 96'(hash_valid), 96'(m_hv));
        check("hash_out", 96'(hash_out), 96'(m_hash));
        check("bloque_bytes", bloque_bytes, exp_block());
        check("target", 96'(target), 96'(m_bytes[12]));
`ifdef CARGA_TIMEOUT_EN
        check("timeout", 96'(timeout), 96'(m_to));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    bit done = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      done = bus.byte_ready;
      tick();
    end
    bus.byte_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: got no byte_ready want accept within 50 cycles");
    end
  endtask

  task automatic load(input logic [7:0] base, input logic [7:0] tgt, input bit gap);
    for (int k = 0; k < 12; k++) begin
      send(base + 8'(k));
      if (gap) tick();
    end
    if (gap) begin
      #1;
      check("gap_not_run_yet", 96'(inicio), 96'(1'b0));
      check("gap_busy", 96'(busy), 96'(1'b1));
    end
    send(tgt);
  endtask

  initial begin
    reset = 1'b1; abortar = 1'b0; terminado = 1'b0; hash_in = '0;
    bus.byte_in = '0; bus.byte_valid = 1'b0;
    repeat (3) tick();
    #1;
    check("rst_hash_out", 96'(hash_out), 96'(24'h0));
    check("rst_inicio", 96'(inicio), 96'(1'b0));
    check("rst_core_reset_n", 96'(core_reset_n), 96'(1'b0));
    check("rst_block", bloque_bytes, 96'h0);
    check("rst_ready", 96'(bus.byte_ready), 96'(1'b0));
    reset = 1'b0;
    #1;
    check("idle_ready", 96'(bus.byte_ready), 96'(1'b1));

    // Back-to-back load
    load(8'h00, 8'h10, 1'b0);
    #1;
    check("t1_block", bloque_bytes, 96'h000102030405060708090A0B);
    check("t1_model_block", exp_block(), 96'h000102030405060708090A0B);
    check("t1_target", 96'(target), 96'(8'h10));
    check("t1_inicio", 96'(inicio), 96'(1'b1));
    check("t1_core_reset_n", 96'(core_reset_n), 96'(1'b1));
    check("t1_ready", 96'(bus.byte_ready), 96'(1'b0));

    // Hash capture
    hash_in = 24'h0A0B0C; terminado = 1'b1;
    tick();
    terminado = 1'b0;
    #1;
    check("t2_hash_out", 96'(hash_out), 96'(24'h0A0B0C));
    check("t2_hash_valid", 96'(hash_valid), 96'(1'b1));
    check("t2_core_reset_n", 96'(core_reset_n), 96'(1'b0));
    tick();
    #1;
    check("t2_hash_valid_off", 96'(hash_valid), 96'(1'b0));
    check("t2_ready", 96'(bus.byte_ready), 96'(1'b1));
    check("t2_hash_held", 96'(hash_out), 96'(24'h0A0B0C));

    // Toggling byte_valid
    load(8'h00, 8'h10, 1'b1);
    #1;
    check("t3_block", bloque_bytes, 96'h000102030405060708090A0B);
    check("t3_target", 96'(target), 96'(8'h10));
    check("t3_inicio", 96'(inicio), 96'(1'b1));
    hash_in = 24'h111111; terminado = 1'b1;
    tick();
    terminado = 1'b0;
    tick();

    // Abort mid-load with a concurrent byte
    for (int k = 0; k < 5; k++) send(8'h50 + 8'(k));
    bus.byte_in = 8'hEE; bus.byte_valid = 1'b1; abortar = 1'b1;
    #1;
    check("t4_ready_abort", 96'(bus.byte_ready), 96'(1'b0));
    tick();
    abortar = 1'b0; bus.byte_valid = 1'b0;
    #1;
    check("t4_busy", 96'(busy), 96'(1'b0));
    check("t4_ready", 96'(bus.byte_ready), 96'(1'b1));
    load(8'h20, 8'h30, 1'b0);
    #1;
    check("t4_block", bloque_bytes, 96'h202122232425262728292A2B);
    check("t4_target", 96'(target), 96'(8'h30));
    terminado = 1'b1;
    tick();
    terminado = 1'b0;
    tick();

    // terminado held through LOAD
    hash_in = 24'h123456; terminado = 1'b1;
    load(8'h40, 8'h4C, 1'b0);
    #1;
    check("t5_no_early_valid", 96'(hash_valid), 96'(1'b0));
    tick();
    terminado = 1'b0;
    #1;
    check("t5_hash_valid", 96'(hash_valid), 96'(1'b1));
    check("t5_hash_out", 96'(hash_out), 96'(24'h123456));
    tick();

`ifdef CARGA_TIMEOUT_EN
    load(8'h60, 8'h6C, 1'b0);
    repeat (15) tick();
    #1;
    check("t6_still_run", 96'(inicio), 96'(1'b1));
    tick();
    #1;
    check("t6_timeout", 96'(timeout), 96'(1'b1));
    check("t6_hash_valid", 96'(hash_valid), 96'(1'b0));
    check("t6_hash_out", 96'(hash_out), 96'(24'h123456));
    check("t6_inicio", 96'(inicio), 96'(1'b0));
    tick();
    send(8'h01);
    #1;
    check("t6_timeout_clr", 96'(timeout), 96'(1'b0));
    abortar = 1'b1;
    tick();
    abortar = 1'b0;
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      abortar        = ($urandom_range(0, 39) == 0);
      terminado      = ($urandom_range(0, 5) == 0);
      bus.byte_valid = ($urandom_range(0, 3) != 0);
      bus.byte_in    = 8'($urandom);
      hash_in        = 24'($urandom);
      tick();
    end

    reset = 1'b1; abortar = 1'b0; terminado = 1'b0; bus.byte_valid = 1'b0;
    repeat (2) tick();
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
